// File: rtl/coherence_memory_control_if.sv
// Cache/RAM side bundle for the dual-core coherence memory controller.
// master = caches + RAM model, slave = controller.
interface coherence_memory_control_if #(
  parameter int CPUS = 2
);
  logic [CPUS-1:0]       iREN;
  logic [CPUS-1:0][31:0] iaddr;
  logic [CPUS-1:0]       dREN;
  logic [CPUS-1:0]       dWEN;
  logic [CPUS-1:0][31:0] daddr;
  logic [CPUS-1:0][31:0] dstore;
  logic [CPUS-1:0]       cctrans;
  logic [CPUS-1:0]       ccwrite;
  logic [CPUS-1:0]       iwait;
  logic [CPUS-1:0][31:0] iload;
  logic [CPUS-1:0]       dwait;
  logic [CPUS-1:0][31:0] dload;
  logic [CPUS-1:0]       ccwait;
  logic [CPUS-1:0]       ccinv;
  logic [CPUS-1:0][31:0] ccsnoopaddr;
  logic                  ramREN;
  logic                  ramWEN;
  logic [31:0]           ramaddr;
  logic [31:0]           ramstore;
  logic [31:0]           ramload;
  logic [1:0]            ramstate;

  modport master (
    output iREN, iaddr, dREN, dWEN,
    output daddr, dstore, cctrans, ccwrite,
    input  iwait, iload, dwait, dload,
    input  ccwait, ccinv, ccsnoopaddr,
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );

  modport slave (
    input  iREN, iaddr, dREN, dWEN,
    input  daddr, dstore, cctrans, ccwrite,
    output iwait, iload, dwait, dload,
    output ccwait, ccinv, ccsnoopaddr,
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );
endinterface

// File: rtl/coherence_memory_control.sv
// Dual-core bus arbiter and MSI snoop controller over one RAM port.
// Arbitration logic is written for two cores (1-bit core index).
module coherence_memory_control #(
  parameter int CPUS = 2
) (
  input logic CLK,
  input logic RST,
  coherence_memory_control_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SNOOP   = 2'd1,
    C2C     = 2'd2,
    RAMXFER = 2'd3
  } state_t;

  localparam logic [1:0] ACCESS = 2'd2;

  state_t r_state;
  logic   r_req;
  logic   r_dlast;
  logic   r_ilast;

  logic            w_acc;
  logic            w_o;
  logic [CPUS-1:0] w_wb;
  logic [CPUS-1:0] w_rd;
  logic            w_wsel;
  logic            w_rsel;
  logic            w_csel;
  logic            w_isel;

  // Prefer the core not served last; else the other one.
  function automatic logic pick(
    input logic [1:0] v,
    input logic       last
  );
    if (v[~last]) return ~last;
    return last;
  endfunction

  assign w_acc  = (bus.ramstate == ACCESS);
  assign w_o    = ~r_req;
  assign w_wb   = bus.dWEN & ~bus.cctrans;
  assign w_rd   = bus.dREN & ~bus.cctrans;
  assign w_wsel = pick(w_wb, r_dlast);
  assign w_rsel = pick(w_rd, r_dlast);
  assign w_csel = pick(bus.cctrans, r_dlast);
  assign w_isel = pick(bus.iREN, r_ilast);

  // Bus/RAM outputs decoded from state and current requests.
  always_comb begin
    bus.iwait    = '1;
    bus.dwait    = '1;
    bus.ccwait   = '0;
    bus.ccinv    = '0;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    for (int i = 0; i < CPUS; i++) begin
      bus.iload[i]       = bus.ramload;
      bus.dload[i]       = bus.ramload;
      bus.ccsnoopaddr[i] = '0;
    end
    unique case (r_state)
      IDLE: begin
        if (|w_wb) begin
          bus.ramWEN   = 1'b1;
          bus.ramaddr  = bus.daddr[w_wsel];
          bus.ramstore = bus.dstore[w_wsel];
          if (w_acc) bus.dwait[w_wsel] = 1'b0;
        end else if (|bus.cctrans) begin
          bus.ramREN = 1'b0;
        end else if (|w_rd) begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.daddr[w_rsel];
          if (w_acc) bus.dwait[w_rsel] = 1'b0;
        end else if (|bus.iREN) begin
          bus.ramREN  = 1'b1;
          bus.ramaddr = bus.iaddr[w_isel];
          if (w_acc) bus.iwait[w_isel] = 1'b0;
        end
      end
      SNOOP, C2C, RAMXFER: begin
        bus.ccwait[w_o]      = 1'b1;
        bus.ccsnoopaddr[w_o] = bus.daddr[r_req];
        bus.ccinv[w_o]       = bus.ccwrite[r_req];
        if (r_state == C2C) begin
          bus.dload[r_req] = bus.dstore[w_o];
          bus.ramWEN       = 1'b1;
          bus.ramaddr      = bus.daddr[w_o];
          bus.ramstore     = bus.dstore[w_o];
          if (w_acc) begin
            bus.dwait[r_req] = 1'b0;
            bus.dwait[w_o]   = 1'b0;
          end
        end else if (r_state == RAMXFER) begin
          bus.ramREN       = 1'b1;
          bus.ramaddr      = bus.daddr[r_req];
          bus.dload[r_req] = bus.ramload;
          if (w_acc) bus.dwait[r_req] = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // FSM, snoop requester and round-robin pointers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_dlast <= 1'b1;
      r_ilast <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (|w_wb) begin
            if (w_acc) r_dlast <= w_wsel;
          end else if (|bus.cctrans) begin
            r_req   <= w_csel;
            r_state <= SNOOP;
          end else if (|w_rd) begin
            if (w_acc) r_dlast <= w_rsel;
          end else if (|bus.iREN) begin
            if (w_acc) r_ilast <= w_isel;
          end
        end
        SNOOP: begin
          if (!bus.cctrans[w_o]) begin
            r_state <= bus.dWEN[w_o] ? C2C : RAMXFER;
          end
        end
        C2C, RAMXFER: begin
          if (w_acc) r_dlast <= r_req;
          if (!bus.cctrans[r_req]) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_memory_control.sv
// Directed bench for coherence_memory_control.
// Inputs change at negedge, outputs sampled 1ns later.
module tb_coherence_memory_control;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   total = 0;
  int   bad   = 0;

  coherence_memory_control_if #(.CPUS(2)) bus();

  coherence_memory_control #(.CPUS(2)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic clr();
    bus.iREN     = '0;
    bus.iaddr    = '0;
    bus.dREN     = '0;
    bus.dWEN     = '0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.cctrans  = '0;
    bus.ccwrite  = '0;
    bus.ramload  = '0;
    bus.ramstate = 2'd1;
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    clr();
    RST = 1'b1;
    tick();
    #1;
    total++;
    if (bus.dwait !== 2'b11 || bus.iwait !== 2'b11) begin
      bad++;
      $display("FAIL rst_waits got=%b/%b exp=11/11",
               bus.dwait, bus.iwait);
    end
    total++;
    if (bus.ccwait !== 2'b00 || bus.ramREN !== 1'b0
        || bus.ramWEN !== 1'b0) begin
      bad++;
      $display("FAIL rst_idle ccwait=%b ren=%b wen=%b",
               bus.ccwait, bus.ramREN, bus.ramWEN);
    end
    RST = 1'b0;
  endtask

  task automatic test_snoop_miss();
    clr();
    RST = 1'b1;
    bus.cctrans  = 2'b11;
    bus.dREN     = 2'b01;
    bus.daddr[0] = 32'h0000ABCD;
    tick();
    RST = 1'b0;
    #1;
    total++;
    if (bus.ramREN !== 1'b0) begin
      bad++;
      $display("FAIL sm_idle_ren got=%b exp=0", bus.ramREN);
    end
    tick();
    #1;
    total++;
    if (bus.ccwait !== 2'b10) begin
      bad++;
      $display("FAIL sm_ccwait got=%b exp=10", bus.ccwait);
    end
    total++;
    if (bus.ccsnoopaddr[1] !== 32'h0000ABCD) begin
      bad++;
      $display("FAIL sm_saddr got=%h exp=0000abcd",
               bus.ccsnoopaddr[1]);
    end
    total++;
    if (bus.dwait !== 2'b11 || bus.ramREN !== 1'b0) begin
      bad++;
      $display("FAIL sm_hold dwait=%b ren=%b exp 11/0",
               bus.dwait, bus.ramREN);
    end
    tick();
    tick();
    #1;
    total++;
    if (bus.ccwait !== 2'b10 || bus.ramREN !== 1'b0) begin
      bad++;
      $display("FAIL sm_hold3 ccwait=%b ren=%b exp 10/0",
               bus.ccwait, bus.ramREN);
    end
    bus.cctrans = 2'b01;
    tick();
    #1;
    total++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h0000ABCD
        || bus.dwait[0] !== 1'b1) begin
      bad++;
      $display("FAIL sm_xfer ren=%b addr=%h dw0=%b exp 1/abcd/1",
               bus.ramREN, bus.ramaddr, bus.dwait[0]);
    end
    bus.ramstate = 2'd2;
    bus.ramload  = 32'h00001234;
    #1;
    total++;
    if (bus.dwait[0] !== 1'b0 || bus.dload[0] !== 32'h1234) begin
      bad++;
      $display("FAIL sm_load dw0=%b dload0=%h exp 0/1234",
               bus.dwait[0], bus.dload[0]);
    end
    total++;
    if (bus.ramWEN !== 1'b0) begin
      bad++;
      $display("FAIL sm_excl wen=%b exp=0", bus.ramWEN);
    end
    clr();
    tick();
  endtask

  task automatic test_c2c();
    clr();
    bus.cctrans  = 2'b01;
    bus.dREN     = 2'b01;
    bus.daddr[0] = 32'h40;
    bus.daddr[1] = 32'h40;
    tick();
    bus.dWEN      = 2'b10;
    bus.dstore[1] = 32'hBEEF;
    #1;
    total++;
    if (bus.ccwait !== 2'b10) begin
      bad++;
      $display("FAIL c2c_snoop ccwait=%b exp=10", bus.ccwait);
    end
    tick();
    bus.ramstate = 2'd2;
    #1;
    total++;
    if (bus.dload[0] !== 32'hBEEF) begin
      bad++;
      $display("FAIL c2c_dload got=%h exp=beef", bus.dload[0]);
    end
    total++;
    if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0
        || bus.ramaddr !== 32'h40
        || bus.ramstore !== 32'hBEEF) begin
      bad++;
      $display("FAIL c2c_ram wen=%b ren=%b a=%h d=%h",
               bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore);
    end
    total++;
    if (bus.dwait !== 2'b00) begin
      bad++;
      $display("FAIL c2c_dwait got=%b exp=00", bus.dwait);
    end
  endtask

  task automatic test_reset_mid();
    bus.ramstate = 2'd1;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    clr();
    #1;
    total++;
    if (bus.ccwait !== 2'b00 || bus.dwait !== 2'b11
        || bus.iwait !== 2'b11 || bus.ramWEN !== 1'b0) begin
      bad++;
      $display("FAIL rmid cw=%b dw=%b iw=%b wen=%b",
               bus.ccwait, bus.dwait, bus.iwait, bus.ramWEN);
    end
  endtask

  task automatic test_invalidate();
    clr();
    bus.cctrans  = 2'b10;
    bus.ccwrite  = 2'b10;
    bus.dREN     = 2'b10;
    bus.daddr[1] = 32'h80;
    tick();
    #1;
    total++;
    if (bus.ccinv !== 2'b01 || bus.ccwait !== 2'b01) begin
      bad++;
      $display("FAIL inv ccinv=%b ccwait=%b exp 01/01",
               bus.ccinv, bus.ccwait);
    end
    total++;
    if (bus.ccsnoopaddr[0] !== 32'h80) begin
      bad++;
      $display("FAIL inv_saddr got=%h exp=80",
               bus.ccsnoopaddr[0]);
    end
    bus.cctrans = 2'b00;
    tick();
    tick();
    clr();
    #1;
    total++;
    if (bus.ccwait !== 2'b00) begin
      bad++;
      $display("FAIL inv_back ccwait=%b exp=00", bus.ccwait);
    end
  endtask

  task automatic test_instr_rr();
    clr();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.iREN     = 2'b11;
    bus.iaddr[0] = 32'h1000;
    bus.iaddr[1] = 32'h2000;
    bus.ramstate = 2'd2;
    #1;
    total++;
    if (bus.iwait !== 2'b10 || bus.ramaddr !== 32'h1000
        || bus.ramREN !== 1'b1) begin
      bad++;
      $display("FAIL irr0 iwait=%b a=%h ren=%b exp 10/1000/1",
               bus.iwait, bus.ramaddr, bus.ramREN);
    end
    tick();
    #1;
    total++;
    if (bus.iwait !== 2'b01 || bus.ramaddr !== 32'h2000) begin
      bad++;
      $display("FAIL irr1 iwait=%b a=%h exp 01/2000",
               bus.iwait, bus.ramaddr);
    end
    tick();
    bus.dREN     = 2'b01;
    bus.daddr[0] = 32'h300;
    #1;
    total++;
    if (bus.iwait !== 2'b11 || bus.dwait !== 2'b10
        || bus.ramaddr !== 32'h300) begin
      bad++;
      $display("FAIL iprio iw=%b dw=%b a=%h exp 11/10/300",
               bus.iwait, bus.dwait, bus.ramaddr);
    end
    tick();
    clr();
  endtask

  task automatic test_data_rr();
    clr();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.dREN     = 2'b11;
    bus.daddr[0] = 32'h500;
    bus.daddr[1] = 32'h600;
    bus.ramstate = 2'd2;
    #1;
    total++;
    if (bus.dwait !== 2'b10 || bus.ramaddr !== 32'h500) begin
      bad++;
      $display("FAIL drr0 dw=%b a=%h exp 10/500",
               bus.dwait, bus.ramaddr);
    end
    tick();
    #1;
    total++;
    if (bus.dwait !== 2'b01 || bus.ramaddr !== 32'h600) begin
      bad++;
      $display("FAIL drr1 dw=%b a=%h exp 01/600",
               bus.dwait, bus.ramaddr);
    end
    tick();
    #1;
    total++;
    if (bus.dwait !== 2'b10 || bus.ramaddr !== 32'h500) begin
      bad++;
      $display("FAIL drr2 dw=%b a=%h exp 10/500",
               bus.dwait, bus.ramaddr);
    end
    clr();
    tick();
  endtask

  task automatic test_writeback();
    clr();
    bus.dWEN      = 2'b10;
    bus.daddr[1]  = 32'h100;
    bus.dstore[1] = 32'hCAFE;
    bus.ramstate  = 2'd3;
    #1;
    total++;
    if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0
        || bus.ramstore !== 32'hCAFE
        || bus.ramaddr !== 32'h100) begin
      bad++;
      $display("FAIL wb_ram wen=%b ren=%b d=%h a=%h",
               bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr);
    end
    total++;
    if (bus.dwait !== 2'b11) begin
      bad++;
      $display("FAIL wb_err dwait=%b exp=11", bus.dwait);
    end
    tick();
    #1;
    total++;
    if (bus.dwait !== 2'b11) begin
      bad++;
      $display("FAIL wb_err2 dwait=%b exp=11", bus.dwait);
    end
    bus.ramstate = 2'd1;
    tick();
    #1;
    total++;
    if (bus.dwait !== 2'b11) begin
      bad++;
      $display("FAIL wb_busy dwait=%b exp=11", bus.dwait);
    end
    bus.ramstate = 2'd2;
    #1;
    total++;
    if (bus.dwait !== 2'b01) begin
      bad++;
      $display("FAIL wb_acc dwait=%b exp=01", bus.dwait);
    end
    tick();
    clr();
  endtask

  initial begin
    clr();
    tick();
    test_reset();
    test_snoop_miss();
    test_c2c();
    test_reset_mid();
    test_invalidate();
    test_instr_rr();
    test_data_rr();
    test_writeback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
